// File: rtl/pixel_scheduler.sv
// Frame scheduler: walks a raymarcher over every pixel in raster order and buffers
// finished pixels in a small FIFO ahead of the framebuffer write port.
module pixel_scheduler #(
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 720,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk_pixel_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  output logic [$clog2(WIDTH)-1:0]           curr_x,
  output logic [$clog2(HEIGHT)-1:0]          curr_y,
  output logic                               march_rst_out,
  input  logic                               pixel_done_in,
  input  logic [7:0]                         red_in,
  input  logic [7:0]                         green_in,
  input  logic [7:0]                         blue_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    fb_addr_out,
  output logic [23:0]                        fb_data_out,
  output logic                               fb_valid_out,
  input  logic                               fb_ready_in,
  output logic                               busy_out,
  output logic                               frame_done_out,
  output logic [15:0]                        frame_count_out
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned AW = $clog2(WIDTH * HEIGHT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    MARCH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic [AW-1:0] pix_addr, addr_n;
  logic          march_rst_n, busy_n, done_n;
  logic [15:0]   fc_n;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic [CW:0]   occ_after;
  logic          push, pop, last_pixel;

  assign push       = (state == MARCH) && pixel_done_in;
  assign pop        = fb_valid_out && fb_ready_in;
  assign count_n    = count + CW'(push) - CW'(pop);
  assign occ_after  = (CW+1)'(count) + (CW+1)'(1) - (CW+1)'(pop);
  assign last_pixel = (curr_x == XW'(WIDTH - 1)) && (curr_y == YW'(HEIGHT - 1));

  assign head        = mem[rd_ptr];
  assign fb_addr_out = fb_valid_out ? head.addr : '0;
  assign fb_data_out = fb_valid_out ? head.data : '0;

  // Next-state and registered-output decode
  always_comb begin
    state_n     = state;
    march_rst_n = 1'b1;
    busy_n      = busy_out;
    done_n      = 1'b0;
    fc_n        = frame_count_out;
    x_n         = curr_x;
    y_n         = curr_y;
    addr_n      = pix_addr;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          x_n     = '0;
          y_n     = '0;
          addr_n  = '0;
          busy_n  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (count < CW'(FIFO_DEPTH)) begin
          march_rst_n = 1'b0;
          state_n     = MARCH;
        end
      end
      MARCH: begin
        march_rst_n = 1'b0;
        if (pixel_done_in) begin
          addr_n = pix_addr + AW'(1);
          if (curr_x == XW'(WIDTH - 1)) begin
            x_n = '0;
            y_n = curr_y + YW'(1);
          end else begin
            x_n = curr_x + XW'(1);
          end
          // Keep marching only if a slot is still free for the next pixel
          if (last_pixel) begin
            x_n         = '0;
            y_n         = '0;
            march_rst_n = 1'b1;
            state_n     = DRAIN;
          end else if (occ_after >= (CW+1)'(FIFO_DEPTH)) begin
            march_rst_n = 1'b1;
            state_n     = ISSUE;
          end
        end
      end
      DRAIN: begin
        if (count == '0) begin
          done_n  = 1'b1;
          fc_n    = frame_count_out + 16'd1;
          busy_n  = 1'b0;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      curr_x          <= '0;
      curr_y          <= '0;
      pix_addr        <= '0;
      march_rst_out   <= 1'b1;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_count_out <= '0;
    end else begin
      state           <= state_n;
      curr_x          <= x_n;
      curr_y          <= y_n;
      pix_addr        <= addr_n;
      march_rst_out   <= march_rst_n;
      busy_out        <= busy_n;
      frame_done_out  <= done_n;
      frame_count_out <= fc_n;
    end
  end

  // FIFO pointers and occupancy; reset discards any buffered pixels
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      fb_valid_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count        <= count_n;
      fb_valid_out <= (count_n != '0);
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (push) mem[wr_ptr] <= '{addr: pix_addr, data: {red_in, green_in, blue_in}};
  end

  push_never_full: assert property (@(posedge clk_pixel_in) disable iff (rst_in)
    !(push && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler with a behavioural raymarcher and raster-order model.
module tb_pixel_scheduler;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic [1:0]  curr_x;
  logic [0:0]  curr_y;
  logic        march_rst_out;
  logic        pixel_done_in = 1'b0;
  logic [7:0]  red_in = '0, green_in = '0, blue_in = '0;
  logic [2:0]  fb_addr_out;
  logic [23:0] fb_data_out;
  logic        fb_valid_out;
  logic        fb_ready_in = 1'b1;
  logic        busy_out;
  logic        frame_done_out;
  logic [15:0] frame_count_out;

  pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
    .clk_pixel_in   (clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .curr_x         (curr_x),
    .curr_y         (curr_y),
    .march_rst_out  (march_rst_out),
    .pixel_done_in  (pixel_done_in),
    .red_in         (red_in),
    .green_in       (green_in),
    .blue_in        (blue_in),
    .fb_addr_out    (fb_addr_out),
    .fb_data_out    (fb_data_out),
    .fb_valid_out   (fb_valid_out),
    .fb_ready_in    (fb_ready_in),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .frame_count_out(frame_count_out)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          n_done = 0;
  int          rm_k = 0;
  int          rm_cnt = 0;
  int          ready_mode = 1;   // 0 low, 1 high, 2 random
  int          exp_fc = 0;
  logic [23:0] colour [N];
  logic [26:0] exp_q [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Ready driver
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       fb_ready_in = 1'b0;
      1:       fb_ready_in = 1'b1;
      default: fb_ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // Raymarcher model: finishes a pixel on the third cycle after release or after its previous pixel
  initial forever begin
    logic consumed;
    @(posedge clk); #1;
    consumed = pixel_done_in;
    if (rst_in) begin
      pixel_done_in = 1'b0;
      rm_cnt = 0;
      rm_k = 0;
    end else begin
      if (consumed) begin
        pixel_done_in = 1'b0;
        rm_k++;
        if (rm_k == N) rm_k = 0;
        else begin
          check("next_coord_x", 32'(curr_x), 32'(rm_k % W));
          check("next_coord_y", 32'(curr_y), 32'(rm_k / W));
        end
      end
      if (march_rst_out || consumed) rm_cnt = 0;
      else begin
        rm_cnt++;
        if (rm_cnt == 3) begin
          check("march_coord_x", 32'(curr_x), 32'(rm_k % W));
          check("march_coord_y", 32'(curr_y), 32'(rm_k / W));
          {red_in, green_in, blue_in} = colour[int'(curr_y) * W + int'(curr_x)];
          pixel_done_in = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted framebuffer write
  initial forever begin
    logic [26:0] e;
    @(negedge clk);
    if (!rst_in && fb_valid_out && fb_ready_in) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none", fb_addr_out, fb_data_out);
      end else begin
        e = exp_q.pop_front();
        check("fb_write", 32'({fb_addr_out, fb_data_out}), 32'(e));
      end
    end
    if (frame_done_out) n_done++;
  end

  task automatic check_reset_outputs();
    check("rst_curr_x", 32'(curr_x), 0);
    check("rst_curr_y", 32'(curr_y), 0);
    check("rst_march_rst", 32'(march_rst_out), 1);
    check("rst_fb_valid", 32'(fb_valid_out), 0);
    check("rst_fb_addr", 32'(fb_addr_out), 0);
    check("rst_fb_data", 32'(fb_data_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_frame_done", 32'(frame_done_out), 0);
    check("rst_frame_count", 32'(frame_count_out), 0);
  endtask

  task automatic start_frame(input bit accepted);
    if (accepted) begin
      for (int i = 0; i < N; i++) begin
        colour[i] = 24'($urandom);
        exp_q.push_back({3'(i), colour[i]});
      end
      exp_fc++;
    end
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (n_done < target && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("frame_done_count", 32'(n_done), 32'(target));
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    check("frame_count", 32'(frame_count_out), 32'(exp_fc));
    check("busy_after_frame", 32'(busy_out), 0);
  endtask

  initial begin
    int base;
    int t;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_in = 1'b0;

    // Single frame with ready always high
    base = n_writes;
    start_frame(1);
    #1 check("busy_after_start", 32'(busy_out), 1);
    wait_frames(1);
    check("frame1_writes", 32'(n_writes - base), N);

    // Start pulsed mid-frame is ignored
    base = n_writes;
    start_frame(1);
    repeat (6) @(posedge clk);
    #1 check("busy_mid_frame", 32'(busy_out), 1);
    start_frame(0);
    wait_frames(2);
    check("ignored_start_writes", 32'(n_writes - base), N);

    // Backpressure: only FIFO_DEPTH pixels may be issued
    base = n_writes;
    ready_mode = 0;
    start_frame(1);
    repeat (60) @(posedge clk);
    #1;
    check("bp_pixels_issued", 32'(rm_k), 4);
    check("bp_march_held", 32'(march_rst_out), 1);
    check("bp_valid", 32'(fb_valid_out), 1);
    check("bp_head_addr", 32'(fb_addr_out), 0);
    repeat (10) @(posedge clk);
    #1;
    check("bp_head_stable", 32'({fb_addr_out, fb_data_out}), 32'({3'd0, colour[0]}));
    ready_mode = 1;
    wait_frames(3);
    check("bp_writes", 32'(n_writes - base), N);

    // Reset after the third write of a frame
    base = n_writes;
    start_frame(1);
    t = 0;
    while (n_writes < base + 3 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("pre_reset_writes", 32'(n_writes - base), 3);
    #1 rst_in = 1'b1;
    exp_q.delete();
    exp_fc = 0;
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    base = n_writes;
    repeat (30) @(posedge clk);
    check("no_write_after_reset", 32'(n_writes - base), 0);
    start_frame(1);
    wait_frames(4);
    check("post_reset_writes", 32'(n_writes - base), N);

    // Three frames under random backpressure
    base = n_writes;
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      start_frame(1);
      wait_frames(5 + f);
    end
    check("random_writes", 32'(n_writes - base), 3 * N);
    check("random_frame_count", 32'(frame_count_out), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
